// File: rtl/pipe_elastic_stage_pkg.sv
// Shared types for the elastic pipeline stage: occupancy width, control states
// and the state-to-occupancy mapping.
package pipe_elastic_stage_pkg;

    localparam int PIPE_OCC_W = 2;

    // Encoding 2'd3 is never entered; the controller treats it as EMPTY.
    typedef enum logic [1:0] {
        PIPE_EMPTY = 2'd0,
        PIPE_ONE   = 2'd1,
        PIPE_TWO   = 2'd2
    } pipe_state_e;

    // Number of payload words held in a given state.
    function automatic logic [PIPE_OCC_W-1:0] stateToOcc(input pipe_state_e s);
        case (s)
            PIPE_ONE: return 2'd1;
            PIPE_TWO: return 2'd2;
            default:  return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_elastic_stage_if.sv
// Handshake bundle between a pipeline stage boundary and its neighbours.
// The slave modport is the stage itself; the master modport is the side that
// drives upstream payload and downstream ready.
interface pipe_elastic_stage_if #(
    parameter int DATA_W = 160
) ();
    import pipe_elastic_stage_pkg::*;

    logic                  flush_i;
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [DATA_W-1:0]     in_data_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [DATA_W-1:0]     out_data_o;
    logic [PIPE_OCC_W-1:0] occ_o;

    modport slave (
        input  flush_i,
        input  in_valid_i,
        output in_ready_o,
        input  in_data_i,
        output out_valid_o,
        input  out_ready_i,
        output out_data_o,
        output occ_o
    );

    modport master (
        output flush_i,
        output in_valid_i,
        input  in_ready_o,
        output in_data_i,
        input  out_valid_o,
        output out_ready_i,
        input  out_data_o,
        input  occ_o
    );

endinterface

// File: rtl/pipe_skid_ctrl.sv
// Occupancy controller for the elastic stage. Tracks how many words are held,
// produces the handshake flags and tells the datapath when to load the main
// and skid registers and where the main register takes its next word from.
module pipe_skid_ctrl
    import pipe_elastic_stage_pkg::*;
#(
    parameter bit SKID = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    input  logic                  out_ready_i,
    output logic                  in_ready_o,
    output logic                  out_valid_o,
    output logic [PIPE_OCC_W-1:0] occ_o,
    output logic                  mainLoad_o,
    output logic                  skidLoad_o,
    output logic                  mainSel_o
);

    pipe_state_e state_q;
    pipe_state_e state_d;
    logic        inFire;
    logic        outFire;

    assign out_valid_o = (state_q == PIPE_ONE) || (state_q == PIPE_TWO);
    assign occ_o       = stateToOcc(state_q);
    assign inFire      = in_valid_i && in_ready_o;
    assign outFire     = out_valid_o && out_ready_i;

    // With a skid entry, ready comes straight from the state flop so the
    // downstream ready never reaches upstream in the same cycle; without it,
    // a full stage can still accept when its word is leaving.
    generate
        if (SKID) begin : g_regReady
            assign in_ready_o = (state_q == PIPE_EMPTY) || (state_q == PIPE_ONE);
        end else begin : g_combReady
            assign in_ready_o = !out_valid_o || out_ready_i;
        end
    endgenerate

    // Next-state and register load decisions; flush wins over any transfer.
    always_comb begin
        state_d    = state_q;
        mainLoad_o = 1'b0;
        skidLoad_o = 1'b0;
        mainSel_o  = 1'b0;
        if (flush_i) begin
            state_d = PIPE_EMPTY;
        end else begin
            case (state_q)
                PIPE_EMPTY: begin
                    if (inFire) begin
                        state_d    = PIPE_ONE;
                        mainLoad_o = 1'b1;
                    end
                end
                PIPE_ONE: begin
                    if (inFire && outFire) begin
                        mainLoad_o = 1'b1;
                    end else if (inFire) begin
                        state_d    = PIPE_TWO;
                        skidLoad_o = 1'b1;
                    end else if (outFire) begin
                        state_d = PIPE_EMPTY;
                    end
                end
                PIPE_TWO: begin
                    if (outFire) begin
                        state_d    = PIPE_ONE;
                        mainLoad_o = 1'b1;
                        mainSel_o  = 1'b1;
                    end
                end
                default: begin
                    state_d = PIPE_EMPTY;
                end
            endcase
        end
    end

    // State register, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PIPE_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/pipe_elastic_stage.sv
// Generic pipeline boundary register: one main payload register that always
// drives the output, plus an optional skid register that catches the word
// arriving in the same cycle the stage fills up.
module pipe_elastic_stage
    import pipe_elastic_stage_pkg::*;
#(
    parameter int               DATA_W    = 160,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    parameter bit               FLUSH_CLR = 1'b1,
    parameter bit               SKID      = 1'b1
) (
    input logic                 clk,
    input logic                 rst,
    pipe_elastic_stage_if.slave pipe
);

    logic              mainLoad;
    logic              skidLoad;
    logic              mainSel;
    logic [DATA_W-1:0] mainData_q;
    logic [DATA_W-1:0] mainData_d;
    logic [DATA_W-1:0] skidData_q;

    pipe_skid_ctrl #(
        .SKID (SKID)
    ) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (pipe.flush_i),
        .in_valid_i  (pipe.in_valid_i),
        .out_ready_i (pipe.out_ready_i),
        .in_ready_o  (pipe.in_ready_o),
        .out_valid_o (pipe.out_valid_o),
        .occ_o       (pipe.occ_o),
        .mainLoad_o  (mainLoad),
        .skidLoad_o  (skidLoad),
        .mainSel_o   (mainSel)
    );

    assign pipe.out_data_o = mainData_q;

    // Main register input: cleared on flush when requested, otherwise loaded
    // only on an actual transfer, from upstream or from the skid entry.
    always_comb begin
        mainData_d = mainData_q;
        if (pipe.flush_i && FLUSH_CLR) begin
            mainData_d = RESET_VAL;
        end else if (mainLoad) begin
            mainData_d = mainSel ? skidData_q : pipe.in_data_i;
        end
    end

    // Main payload register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mainData_q <= RESET_VAL;
        end else begin
            mainData_q <= mainData_d;
        end
    end

    generate
        if (SKID) begin : g_skid
            logic [DATA_W-1:0] skidData_d;

            // Skid register input: cleared on flush when requested, loaded
            // only when upstream delivers into an already occupied stage.
            always_comb begin
                skidData_d = skidData_q;
                if (pipe.flush_i && FLUSH_CLR) begin
                    skidData_d = RESET_VAL;
                end else if (skidLoad) begin
                    skidData_d = pipe.in_data_i;
                end
            end

            // Skid payload register.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    skidData_q <= RESET_VAL;
                end else begin
                    skidData_q <= skidData_d;
                end
            end
        end else begin : g_noSkid
            assign skidData_q = RESET_VAL;
        end
    endgenerate

endmodule
